// File: rtl/ghost_chase_fsm.sv
// Per-ghost movement controller: on each tick ranks four headings against Pacman,
// asks the maze wall lookup about each candidate step in turn and takes the first legal one.
module ghost_chase_fsm #(
    parameter int unsigned X_HOME     = 320,
    parameter int unsigned Y_HOME     = 240,
    parameter int unsigned STEP       = 4,
    parameter int unsigned X_MIN      = 16,
    parameter int unsigned X_MAX      = 623,
    parameter int unsigned Y_MIN      = 16,
    parameter int unsigned Y_MAX      = 463,
    parameter int unsigned CATCH_DIST = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       fright,
    input  logic [9:0] pac_x,
    input  logic [9:0] pac_y,
    output logic       q_req,
    output logic [9:0] q_x,
    output logic [8:0] q_y,
    input  logic       q_ack,
    input  logic       q_blocked,
    output logic [9:0] ghost_x,
    output logic [8:0] ghost_y,
    output logic [1:0] dir,
    output logic       busy,
    output logic       stuck,
    output logic       catch
);

    // state | meaning
    // IDLE  | waiting for a movement tick
    // PICK  | rank the four headings into ord_q
    // QUERY | bounds-check candidate idx_q, issue wall query if in range
    // WAIT  | wait for the wall lookup answer
    // MOVE  | commit the accepted step and heading
    // FAIL  | every candidate rejected, pulse stuck
    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_QUERY,
        S_WAIT,
        S_MOVE,
        S_FAIL
    } state_t;

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    localparam logic [10:0] X_LO    = 11'(X_MIN);
    localparam logic [10:0] X_HI    = 11'(X_MAX);
    localparam logic [9:0]  Y_LO    = 10'(Y_MIN);
    localparam logic [9:0]  Y_HI    = 10'(Y_MAX);
    localparam logic [10:0] STEP_X  = 11'(STEP);
    localparam logic [9:0]  STEP_Y  = 10'(STEP);
    localparam logic [10:0] CATCH_W = 11'(CATCH_DIST);

    state_t      state, state_n;
    logic [7:0]  ord_q, ord_n;
    logic [1:0]  idx_q, idx_n;
    logic [1:0]  cand;
    logic [10:0] tx;
    logic [9:0]  ty;
    logic        in_range;

    logic [10:0] dx, dy, adx, ady;
    logic        h_pri;
    logic [1:0]  h_tow, v_tow, p_t, s_t, p_a, s_a, rev;
    logic [7:0]  ord_pick;

    // Deltas are 11-bit two's complement; bit 10 is the sign.
    always_comb begin
        dx  = {1'b0, pac_x} - {1'b0, ghost_x};
        dy  = {1'b0, pac_y} - {2'b00, ghost_y};
        adx = dx[10] ? (11'd0 - dx) : dx;
        ady = dy[10] ? (11'd0 - dy) : dy;
    end

    // Reversal of any heading is heading ^ 1 with this encoding.
    always_comb begin
        h_pri = (adx >= ady);
        h_tow = (dx[10] ? D_LEFT : D_RIGHT) ^ {1'b0, fright};
        v_tow = (dy[10] ? D_UP : D_DOWN) ^ {1'b0, fright};
        p_t   = h_pri ? h_tow : v_tow;
        s_t   = h_pri ? v_tow : h_tow;
        p_a   = p_t ^ 2'd1;
        s_a   = s_t ^ 2'd1;
        rev   = dir ^ 2'd1;
        if (p_t == rev) begin
            ord_pick = {rev, p_a, s_a, s_t};
        end else if (s_t == rev) begin
            ord_pick = {rev, p_a, s_a, p_t};
        end else if (s_a == rev) begin
            ord_pick = {rev, p_a, s_t, p_t};
        end else begin
            ord_pick = {rev, s_a, s_t, p_t};
        end
    end

    always_comb begin
        cand = ord_q[{idx_q, 1'b0} +: 2];
        tx   = {1'b0, ghost_x};
        ty   = {1'b0, ghost_y};
        case (cand)
            D_UP:    ty = ty - STEP_Y;
            D_DOWN:  ty = ty + STEP_Y;
            D_LEFT:  tx = tx - STEP_X;
            default: tx = tx + STEP_X;
        endcase
        in_range = (tx >= X_LO) && (tx <= X_HI) && (ty >= Y_LO) && (ty <= Y_HI);
    end

    assign q_x  = tx[9:0];
    assign q_y  = ty[8:0];
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ord_q <= '0;
            idx_q <= '0;
        end else begin
            state <= state_n;
            ord_q <= ord_n;
            idx_q <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        ord_n   = ord_q;
        idx_n   = idx_q;
        q_req   = 1'b0;
        stuck   = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) state_n = S_PICK;
            end
            S_PICK: begin
                ord_n   = ord_pick;
                idx_n   = 2'd0;
                state_n = S_QUERY;
            end
            S_QUERY: begin
                if (in_range) begin
                    q_req   = 1'b1;
                    state_n = S_WAIT;
                end else if (idx_q == 2'd3) begin
                    state_n = S_FAIL;
                end else begin
                    idx_n = idx_q + 2'd1;
                end
            end
            S_WAIT: begin
                if (q_ack) begin
                    if (!q_blocked) begin
                        state_n = S_MOVE;
                    end else if (idx_q == 2'd3) begin
                        state_n = S_FAIL;
                    end else begin
                        idx_n   = idx_q + 2'd1;
                        state_n = S_QUERY;
                    end
                end
            end
            S_MOVE: begin
                state_n = S_IDLE;
            end
            S_FAIL: begin
                stuck   = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // In MOVE the candidate index is still the accepted one, so tx/ty are the target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghost_x <= 10'(X_HOME);
            ghost_y <= 9'(Y_HOME);
            dir     <= D_LEFT;
        end else if (state == S_MOVE) begin
            ghost_x <= tx[9:0];
            ghost_y <= ty[8:0];
            dir     <= cand;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            catch <= 1'b0;
        end else begin
            catch <= (adx < CATCH_W) && (ady < CATCH_W);
        end
    end

endmodule

// File: tb/tb_ghost_chase_fsm.sv
// Bench for ghost_chase_fsm: directed latency/reset/bounds sequences, a table of
// ranking vectors, and randomized searches against a score-based reference model.
module tb_ghost_chase_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       fright = 1'b0;
    logic [9:0] pac_x = '0;
    logic [9:0] pac_y = '0;
    logic       q_req;
    logic [9:0] q_x;
    logic [8:0] q_y;
    logic       q_ack = 1'b0;
    logic       q_blocked = 1'b0;
    logic [9:0] ghost_x;
    logic [8:0] ghost_y;
    logic [1:0] dir;
    logic       busy;
    logic       stuck;
    logic       catch;

    ghost_chase_fsm dut (
        .clk(clk), .rst(rst), .tick(tick), .fright(fright),
        .pac_x(pac_x), .pac_y(pac_y),
        .q_req(q_req), .q_x(q_x), .q_y(q_y),
        .q_ack(q_ack), .q_blocked(q_blocked),
        .ghost_x(ghost_x), .ghost_y(ghost_y), .dir(dir),
        .busy(busy), .stuck(stuck), .catch(catch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // search observer results
    int         seen_n;
    int         seen_stuck;
    logic [9:0] seen_x [8];
    logic [8:0] seen_y [8];

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        tick = 1'b0; q_ack = 1'b0; q_blocked = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Fires one tick, answers every query (first nblock blocked, ack after delay+1 cycles).
    task automatic run_search(input int nblock, input int delay);
        int budget;
        bit unstable;
        bit done;
        logic [9:0] hx;
        logic [8:0] hy;
        seen_n = 0; seen_stuck = 0; budget = 0; unstable = 0; done = 0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        while (budget < 120 && !done) begin
            if (stuck) seen_stuck++;
            if (q_req) begin
                hx = q_x; hy = q_y;
                if (seen_n < 8) begin
                    seen_x[seen_n] = q_x;
                    seen_y[seen_n] = q_y;
                end
                for (int w = 0; w < delay + 1; w++) begin
                    @(negedge clk);
                    if (q_x !== hx || q_y !== hy) unstable = 1;
                end
                q_ack = 1'b1; q_blocked = (seen_n < nblock);
                seen_n++;
                @(negedge clk);
                q_ack = 1'b0; q_blocked = 1'b0;
                budget += delay + 2;
            end else if (!busy) begin
                done = 1;
            end else begin
                @(negedge clk);
                budget++;
            end
        end
        chk("search_finished", {31'd0, done}, 32'd1);
        chk("query_stable", {31'd0, unstable}, 32'd0);
    endtask

    // ---------------- reference model ----------------
    function automatic int rev_of(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Score each heading: 0 primary-toward, 1 secondary-toward, 2 secondary-away,
    // 3 primary-away (toward/away flipped when frightened), reversal of heading last.
    function automatic logic [7:0] m_order(input int gx, input int gy, input int px,
                                           input int py, input bit fr, input int hd);
        int dxv, dyv, sc[4], slot;
        bit hpri, horiz, tow;
        logic [7:0] res;
        dxv = px - gx; dyv = py - gy;
        hpri = iabs(dxv) >= iabs(dyv);
        for (int d = 0; d < 4; d++) begin
            horiz = (d >= 2);
            if (horiz) tow = (d == ((dxv >= 0) ? 3 : 2));
            else       tow = (d == ((dyv >= 0) ? 1 : 0));
            tow = tow ^ fr;
            if (horiz == hpri) sc[d] = tow ? 0 : 3;
            else               sc[d] = tow ? 1 : 2;
            if (d == rev_of(hd)) sc[d] = 9;
        end
        res = '0; slot = 0;
        for (int s = 0; s < 10; s++)
            for (int d = 0; d < 4; d++)
                if (sc[d] == s) begin
                    res[slot*2 +: 2] = 2'(d);
                    slot++;
                end
        return res;
    endfunction

    function automatic int step_x(input int d);
        return (d == 3) ? 4 : (d == 2) ? -4 : 0;
    endfunction

    function automatic int step_y(input int d);
        return (d == 1) ? 4 : (d == 0) ? -4 : 0;
    endfunction

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       fr;
        logic [1:0] d0, d1, d2, d3;
    } vec_t;

    vec_t vecs[8];

    int mx, my, mdir;
    int ex[4], ey[4], ed[4], en;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int qcount, nb, dl, expq, cx, cy;
        logic [7:0] ord;
        logic [1:0] dseq[4];
        logic [9:0] cpx[5];
        logic [9:0] cpy[5];
        logic       cexp[5];

        // ranking vectors from home (320,240) heading LEFT, so RIGHT always ranks last
        vecs[0] = '{10'd300, 10'd200, 1'b0, 2'd0, 2'd2, 2'd1, 2'd3};
        vecs[1] = '{10'd300, 10'd200, 1'b1, 2'd1, 2'd2, 2'd0, 2'd3};
        vecs[2] = '{10'd400, 10'd250, 1'b0, 2'd1, 2'd0, 2'd2, 2'd3};
        vecs[3] = '{10'd320, 10'd240, 1'b0, 2'd1, 2'd0, 2'd2, 2'd3};
        vecs[4] = '{10'd100, 10'd500, 1'b0, 2'd1, 2'd2, 2'd0, 2'd3};
        vecs[5] = '{10'd310, 10'd230, 1'b1, 2'd1, 2'd0, 2'd2, 2'd3};
        vecs[6] = '{10'd330, 10'd100, 1'b1, 2'd1, 2'd2, 2'd0, 2'd3};
        vecs[7] = '{10'd330, 10'd100, 1'b0, 2'd0, 2'd2, 2'd1, 2'd3};

        // reset state
        @(negedge clk);
        chk("rst_ghost_x", ghost_x, 320);
        chk("rst_ghost_y", ghost_y, 240);
        chk("rst_dir", dir, 2);
        chk("rst_busy", busy, 0);
        chk("rst_q_req", q_req, 0);
        chk("rst_stuck", stuck, 0);
        chk("rst_catch", catch, 0);
        rst = 1'b0;

        // chase in an open maze with exact latency
        do_reset();
        pac_x = 300; pac_y = 200; fright = 0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        chk("lat_c1_busy", busy, 1);
        chk("lat_c1_q_req", q_req, 0);
        @(negedge clk);
        chk("lat_c2_q_req", q_req, 1);
        chk("lat_c2_q_x", q_x, 320);
        chk("lat_c2_q_y", q_y, 236);
        @(negedge clk);
        chk("lat_c3_q_req", q_req, 0);
        q_ack = 1'b1;
        @(negedge clk);
        q_ack = 1'b0;
        chk("lat_c4_ghost_y", ghost_y, 240);
        @(negedge clk);
        chk("lat_c5_ghost_x", ghost_x, 320);
        chk("lat_c5_ghost_y", ghost_y, 236);
        chk("lat_c5_dir", dir, 0);
        chk("lat_c5_busy", busy, 0);

        // catch asserted, then an asynchronous mid-cycle reset clears everything at once
        pac_x = 320; pac_y = 238;
        @(negedge clk); @(negedge clk);
        chk("pre_rst_catch", catch, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_ghost_x", ghost_x, 320);
        chk("async_ghost_y", ghost_y, 240);
        chk("async_dir", dir, 2);
        chk("async_catch", catch, 0);
        chk("async_busy", busy, 0);
        @(negedge clk); rst = 1'b0;

        // blocked primary: second candidate LEFT is taken
        do_reset();
        pac_x = 300; pac_y = 200; fright = 0;
        run_search(1, 0);
        chk("blk_nq", seen_n, 2);
        chk("blk_q2_x", seen_x[1], 316);
        chk("blk_q2_y", seen_y[1], 240);
        chk("blk_ghost_x", ghost_x, 316);
        chk("blk_ghost_y", ghost_y, 240);
        chk("blk_dir", dir, 2);

        // tick during WAIT is dropped
        do_reset();
        pac_x = 300; pac_y = 200; fright = 0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        chk("drop_q_req", q_req, 1);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        chk("drop_wait_busy", busy, 1);
        q_ack = 1'b1;
        @(negedge clk); q_ack = 1'b0;
        @(negedge clk);
        chk("drop_idle_busy", busy, 0);
        chk("drop_ghost_y", ghost_y, 236);
        qcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (q_req || busy) qcount++;
        end
        chk("drop_no_second_search", qcount, 0);

        // reset during WAIT, late q_ack ignored
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        chk("rstw_q_req", q_req, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rstw_busy", busy, 0);
        @(negedge clk); rst = 1'b0;
        q_ack = 1'b1; q_blocked = 1'b0;
        @(negedge clk); @(negedge clk);
        q_ack = 1'b0;
        chk("rstw_ghost_x", ghost_x, 320);
        chk("rstw_ghost_y", ghost_y, 240);
        chk("rstw_dir", dir, 2);
        chk("rstw_busy_after", busy, 0);

        // ranking table, every answer blocked
        foreach (vecs[v]) begin
            do_reset();
            pac_x = vecs[v].px; pac_y = vecs[v].py; fright = vecs[v].fr;
            dseq[0] = vecs[v].d0; dseq[1] = vecs[v].d1;
            dseq[2] = vecs[v].d2; dseq[3] = vecs[v].d3;
            run_search(4, 0);
            chk($sformatf("vec%0d_nq", v), seen_n, 4);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("vec%0d_q%0d_x", v, i), seen_x[i], 320 + step_x(int'(dseq[i])));
                chk($sformatf("vec%0d_q%0d_y", v, i), seen_y[i], 240 + step_y(int'(dseq[i])));
            end
            chk($sformatf("vec%0d_stuck", v), seen_stuck, 1);
            chk($sformatf("vec%0d_ghost_x", v), ghost_x, 320);
            chk($sformatf("vec%0d_ghost_y", v), ghost_y, 240);
            chk($sformatf("vec%0d_dir", v), dir, 2);
        end
        fright = 0;

        // walk to X_MIN, then LEFT must be rejected without a query
        do_reset();
        pac_x = 0; pac_y = 240;
        for (int i = 0; i < 100 && ghost_x > 16; i++) run_search(0, 0);
        chk("bnd_reach_xmin", ghost_x, 16);
        run_search(0, 0);
        chk("bnd_nq", seen_n, 1);
        chk("bnd_first_q_x", seen_x[0], 16);
        chk("bnd_first_q_y", seen_y[0], 244);
        chk("bnd_ghost_y", ghost_y, 244);
        chk("bnd_dir", dir, 1);

        // catch window edges around home
        cpx[0] = 322; cpy[0] = 241; cexp[0] = 1;
        cpx[1] = 328; cpy[1] = 240; cexp[1] = 0;
        cpx[2] = 313; cpy[2] = 233; cexp[2] = 1;
        cpx[3] = 312; cpy[3] = 240; cexp[3] = 0;
        cpx[4] = 320; cpy[4] = 247; cexp[4] = 1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pac_x = cpx[i]; pac_y = cpy[i];
            @(negedge clk); @(negedge clk);
            chk($sformatf("catch%0d", i), catch, cexp[i]);
        end

        // randomized searches against the model
        do_reset();
        mx = 320; my = 240; mdir = 2;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(3) == 0) begin
                cx = mx + $urandom_range(18) - 9;
                cy = my + $urandom_range(18) - 9;
                pac_x = 10'(cx); pac_y = 10'(cy);
            end else begin
                pac_x = 10'($urandom_range(639));
                pac_y = 10'($urandom_range(479));
            end
            fright = 1'($urandom_range(1));
            nb = $urandom_range(4);
            dl = $urandom_range(2);
            ord = m_order(mx, my, int'(pac_x), int'(pac_y), fright, mdir);
            en = 0;
            for (int i = 0; i < 4; i++) begin
                cx = mx + step_x(int'(ord[i*2 +: 2]));
                cy = my + step_y(int'(ord[i*2 +: 2]));
                if (cx >= 16 && cx <= 623 && cy >= 16 && cy <= 463) begin
                    ex[en] = cx; ey[en] = cy; ed[en] = int'(ord[i*2 +: 2]);
                    en++;
                end
            end
            run_search(nb, dl);
            expq = (nb >= en) ? en : nb + 1;
            chk($sformatf("rnd%0d_nq", it), seen_n, expq);
            for (int i = 0; i < expq && i < seen_n; i++) begin
                chk($sformatf("rnd%0d_q%0d_x", it, i), seen_x[i], ex[i]);
                chk($sformatf("rnd%0d_q%0d_y", it, i), seen_y[i], ey[i]);
            end
            chk($sformatf("rnd%0d_stuck", it), seen_stuck, (nb >= en) ? 1 : 0);
            if (nb < en) begin
                mx = ex[nb]; my = ey[nb]; mdir = ed[nb];
            end
            chk($sformatf("rnd%0d_ghost_x", it), ghost_x, mx);
            chk($sformatf("rnd%0d_ghost_y", it), ghost_y, my);
            chk($sformatf("rnd%0d_dir", it), dir, mdir);
            @(negedge clk);
            chk($sformatf("rnd%0d_catch", it), catch,
                (iabs(int'(pac_x) - mx) < 8 && iabs(int'(pac_y) - my) < 8) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
